// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the circular priority pick used by the FIFO write arbiter.
package fifo_wr_arbiter_pkg;

  localparam int MAX_REQ = 8;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  // One-hot of the first set bit of req at or after start, wrapping at n.
  function automatic logic [MAX_REQ-1:0] rr_first(input logic [MAX_REQ-1:0] req,
                                                  input int start,
                                                  input int n);
    logic [MAX_REQ-1:0] g;
    int idx;
    g = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = start + k;
      if (idx >= n) idx = idx - n;
      if (k < n && g == '0 && req[3'(idx)]) g[3'(idx)] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selection: first unmasked requester at or after ptr.
module fifo_wr_arbiter_rr_pick
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int PW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic [NUM_REQ-1:0] excl,
  output logic [NUM_REQ-1:0] gnt
);

  logic [MAX_REQ-1:0] cand;
  logic [MAX_REQ-1:0] pick;
  logic               unused_pick;

  always_comb begin
    cand = '0;
    cand[NUM_REQ-1:0] = req & ~excl;
    pick = rr_first(cand, int'(ptr), NUM_REQ);
    gnt  = pick[NUM_REQ-1:0];
  end

  assign unused_pick = ^pick;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port, with a registered
// write stage and a shadow occupancy count that prevents overflow.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BURST_LEN  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  output logic [NUM_REQ-1:0]               gnt,
  output logic                             fifo_wr,
  output logic [DATA_WIDTH-1:0]            fifo_data,
  input  logic                             fifo_rd,
  input  logic                             fifo_empty,
  input  logic                             fifo_overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
  output logic                             ovf_err
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int LW = $clog2(FIFO_DEPTH+1);
  localparam int BW = $clog2(BURST_LEN+1);

  // Handshake: req[i] is the producer's valid and must stay high with stable
  // data until gnt[i]; gnt[i] high in a cycle means the word transfers at that
  // rising edge. A producer may drop req without a grant to end its burst.

  state_t               state, state_nxt;
  logic [PW-1:0]        owner, owner_nxt, rr_ptr, rr_ptr_nxt;
  logic [PW-1:0]        owner_inc, pick_ptr, pick_idx;
  logic [BW-1:0]        beat, beat_nxt;
  logic [NUM_REQ-1:0]   excl, pick_gnt;
  logic                 space, hold, accept, rd_eff;
  logic [DATA_WIDTH-1:0] gnt_data;

  assign space     = level < LW'(FIFO_DEPTH);
  assign hold      = (state == OWN) && req[owner] && (beat < BW'(BURST_LEN));
  assign owner_inc = (owner == PW'(NUM_REQ-1)) ? '0 : owner + 1'b1;
  // After a burst the search starts just past the old owner, making it last.
  assign pick_ptr  = (state == OWN) ? owner_inc : rr_ptr;
  assign excl      = {NUM_REQ{rst}};
  assign accept    = |gnt;
  assign rd_eff    = fifo_rd && !fifo_empty;

  fifo_wr_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PW      (PW)
  ) u_pick (
    .req  (req),
    .ptr  (pick_ptr),
    .excl (excl),
    .gnt  (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_gnt[i]) pick_idx = PW'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      owner  <= '0;
      rr_ptr <= '0;
      beat   <= '0;
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      rr_ptr <= rr_ptr_nxt;
      beat   <= beat_nxt;
    end
  end

  // A stall freezes ownership entirely; burst ends are resolved once space returns.
  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_ptr_nxt = rr_ptr;
    beat_nxt   = beat;
    if (space) begin
      if (state == IDLE) begin
        if (|pick_gnt) begin
          state_nxt = OWN;
          owner_nxt = pick_idx;
          beat_nxt  = BW'(1);
        end
      end else if (hold) begin
        beat_nxt = beat + 1'b1;
      end else begin
        rr_ptr_nxt = owner_inc;
        if (|pick_gnt) begin
          owner_nxt = pick_idx;
          beat_nxt  = BW'(1);
        end else begin
          state_nxt = IDLE;
          beat_nxt  = '0;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (space && !rst) begin
      if (hold) gnt[owner] = 1'b1;
      else      gnt = pick_gnt;
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) gnt_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_wr   <= 1'b0;
      fifo_data <= '0;
      level     <= '0;
      ovf_err   <= 1'b0;
    end else begin
      fifo_wr <= accept;
      if (accept) fifo_data <= gnt_data;
      if (accept && !rd_eff)
        level <= level + 1'b1;
      else if (!accept && rd_eff && level != '0)
        level <= level - 1'b1;
      if (fifo_overflow) ovf_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// compared every cycle against a queue-based behavioural model.
module tb_fifo_wr_arbiter;
  import fifo_wr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 16;
  localparam int B  = 4;
  localparam int PW = 2;
  localparam int LW = $clog2(D+1);

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic           fifo_wr;
  logic [W-1:0]   fifo_data;
  logic           fifo_rd, fifo_empty, fifo_overflow;
  logic [LW-1:0]  level;
  logic           ovf_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (W),
    .FIFO_DEPTH (D),
    .BURST_LEN  (B)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .req_data      (req_data),
    .gnt           (gnt),
    .fifo_wr       (fifo_wr),
    .fifo_data     (fifo_data),
    .fifo_rd       (fifo_rd),
    .fifo_empty    (fifo_empty),
    .fifo_overflow (fifo_overflow),
    .level         (level),
    .ovf_err       (ovf_err)
  );

  // behavioural model state
  int           m_owner = -1;
  int           m_beat  = 0;
  int           m_ptr   = 0;
  int           m_level = 0;
  bit           m_wr    = 1'b0;
  bit           m_ovf   = 1'b0;
  logic [W-1:0] exp_q[$];

  bit           log_en = 1'b0;
  int           seq_q[$];
  int           n_gnt = 0;
  int           n_wr  = 0;
  logic [N-1:0] gnt_seen = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [N-1:0] r, input int start);
    int idx;
    for (int k = 0; k < N; k++) begin
      idx = (start + k) % N;
      if (r[idx[PW-1:0]]) return idx;
    end
    return -1;
  endfunction

  // compare process: check DUT against the model, then advance the model
  always @(negedge clk) begin : cmp
    int e;
    bit cont, rd, acc;
    logic [N-1:0] eg;
    e    = -1;
    cont = (m_owner >= 0) && req[m_owner[PW-1:0]] && (m_beat < B);
    if (!rst && m_level < D) begin
      if (cont) e = m_owner;
      else      e = first_from(req, (m_owner >= 0) ? (m_owner + 1) % N : m_ptr);
    end
    eg = '0;
    if (e >= 0) eg[e[PW-1:0]] = 1'b1;

    check("gnt", gnt, eg);
    check("fifo_wr", fifo_wr, m_wr);
    check("level", level, m_level);
    check("ovf_err", ovf_err, m_ovf);
    if (fifo_wr === 1'b1) begin
      n_wr++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL fifo_data: write of %0h with no accepted word at %0t", fifo_data, $time);
      end else begin
        check("fifo_data", fifo_data, exp_q.pop_front());
      end
    end
    if (|gnt) n_gnt++;
    gnt_seen = gnt;
    if (log_en)
      for (int i = 0; i < N; i++) if (gnt[i]) seq_q.push_back(i);

    rd  = fifo_rd && !fifo_empty;
    acc = (e >= 0);
    if (rst) begin
      m_owner = -1; m_beat = 0; m_ptr = 0; m_level = 0;
      m_wr = 1'b0; m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      if (m_level < D) begin
        if (cont) m_beat++;
        else begin
          if (m_owner >= 0) m_ptr = (m_owner + 1) % N;
          if (e >= 0) begin m_owner = e; m_beat = 1; end
          else begin m_owner = -1; m_beat = 0; end
        end
      end
      m_wr = acc;
      if (acc) exp_q.push_back(req_data[e*W +: W]);
      if (acc && !rd) m_level++;
      else if (!acc && rd && m_level > 0) m_level--;
      m_ovf = m_ovf | fifo_overflow;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  int exp_seq[17] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0};

  initial begin
    rst = 1'b1; req = '1; req_data = '0;
    fifo_rd = 1'b0; fifo_empty = 1'b1; fifo_overflow = 1'b0;

    // reset: requests held high must not be granted
    do_reset(2);
    req = '0;
    check("rst_level", level, 0);
    check("rst_fifo_wr", fifo_wr, 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_ovf", ovf_err, 0);
    check("rst_state", dut.state, IDLE);
    check("rst_ptr", dut.rr_ptr, 0);
    check("rst_beat", dut.beat, 0);

    // single producer fills the FIFO
    n_gnt = 0; n_wr = 0;
    req = 4'b0001; req_data[7:0] = 8'h01;
    repeat (24) begin
      tick();
      if (gnt_seen[0]) req_data[7:0] = req_data[7:0] + 8'h01;
    end
    check("single_gnts", n_gnt, 16);
    check("single_wrs", n_wr, 16);
    check("single_level", level, 16);
    check("single_gnt_idle", gnt, 0);
    check("single_ovf", ovf_err, 0);

    // burst and rotation with reads keeping the level low
    req = '0; do_reset(1);
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111; fifo_rd = 1'b1; fifo_empty = 1'b0;
    seq_q.delete(); log_en = 1'b1;
    repeat (18) tick();
    log_en = 1'b0;
    check("rot_len_ok", seq_q.size() >= 17, 1);
    for (int i = 0; i < 17 && i < seq_q.size(); i++) check("rot_seq", seq_q[i], exp_seq[i]);

    // early release of producer 2 after two beats
    req = '0; fifo_rd = 1'b0; fifo_empty = 1'b1; do_reset(1);
    req = 4'b1100;
    tick(); tick();
    req = 4'b1000;
    @(negedge clk);
    check("early_gnt", gnt, 4'b1000);
    tick();
    check("early_ptr", dut.rr_ptr, 3);
    check("early_beat", dut.beat, 1);

    // backpressure at full, one read releases one more beat
    req = '0; do_reset(1);
    req = 4'b0001;
    repeat (14) tick();
    check("bp_level14", level, 14);
    req = 4'b0010;
    tick(); tick();
    check("bp_level16", level, 16);
    check("bp_beat2", dut.beat, 2);
    fifo_rd = 1'b1; fifo_empty = 1'b0;
    @(negedge clk);
    check("bp_stall", gnt, 0);
    tick();
    fifo_rd = 1'b0; fifo_empty = 1'b1;
    check("bp_level15", level, 15);
    @(negedge clk);
    check("bp_regrant", gnt, 4'b0010);
    tick();
    check("bp_level_back", level, 16);
    check("bp_beat3", dut.beat, 3);

    // reset in the middle of a burst
    req = '0; do_reset(1);
    req = 4'b0110;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; req = 4'b0011;
    check("mid_rst_wr", fifo_wr, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_state", dut.state, IDLE);
    @(negedge clk);
    check("mid_rst_gnt", gnt, 4'b0001);
    tick();

    // overflow monitor is sticky until reset
    req = '0;
    fifo_overflow = 1'b1;
    tick();
    fifo_overflow = 1'b0;
    check("ovf_set", ovf_err, 1);
    repeat (5) tick();
    check("ovf_sticky", ovf_err, 1);
    do_reset(1);
    check("ovf_clear", ovf_err, 0);

    // randomized traffic
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt_seen[i]) begin
          req[i] = ($urandom_range(0, 1) == 1);
          req_data[i*W +: W] = W'($urandom_range(0, 255));
        end else if (req[i]) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          req_data[i*W +: W] = W'($urandom_range(0, 255));
        end
      end
      fifo_rd       = ($urandom_range(0, 1) == 1);
      fifo_empty    = ($urandom_range(0, 3) == 0);
      fifo_overflow = ($urandom_range(0, 199) == 0);
      rst           = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0; req = '0; fifo_rd = 1'b0; fifo_overflow = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
